// File: rtl/ahb_ral_cmd_master.sv
// Command-driven AHB-Lite master: FIFO-buffered read/write commands, one SINGLE transfer at a time.
// Optional data-phase timeout enabled by defining AHB_CMD_MASTER_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | waiting for a queued command, pops it when present
// S_ADDR | address phase driven (hsel=1, NONSEQ)
// S_DATA | data phase, waiting for hready
// S_RSP  | response held until rsp_ready
module ahb_ral_cmd_master #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        hsel,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RSP} state_t;

  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(CMD_DEPTH);

  state_t        state, state_nxt;
  logic [64:0]   fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic [64:0]   head;
  logic [31:0]   cur_wdata;
  logic          push, pop, tmo_hit;

  assign hsize  = 3'b010;
  assign hburst = 3'b000;
  assign push   = cmd_valid & cmd_ready;
  assign head   = fifo_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: if (count != '0) begin
        pop       = 1'b1;
        state_nxt = (head[33:32] != 2'b00) ? S_RSP : S_ADDR;
      end
      S_ADDR: if (hready) state_nxt = S_DATA;
      S_DATA: if (hready || tmo_hit) state_nxt = S_RSP;
      S_RSP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge hclk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // cmd_ready is registered so it stays low throughout reset
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      count     <= count_nxt;
      cmd_ready <= (count_nxt != DEPTH_C);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hsel      <= 1'b0;
      htrans    <= 2'b00;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      cur_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      hsel      <= (state_nxt == S_ADDR);
      htrans    <= (state_nxt == S_ADDR) ? 2'b10 : 2'b00;
      rsp_valid <= (state_nxt == S_RSP);
      if (pop) begin
        cur_wdata <= head[31:0];
        if (head[33:32] != 2'b00) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          haddr  <= head[63:32];
          hwrite <= head[64];
        end
      end
      if (state == S_ADDR && hready) hwdata <= cur_wdata;
      if (state == S_DATA) begin
        if (hready) begin
          rsp_err   <= hresp;
          rsp_rdata <= (!hwrite && !hresp) ? hrdata : 32'h0;
        end else if (tmo_hit) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= 32'h0BAD_0BAD;
        end
      end
    end
  end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // Down-counter reloads whenever the slave is not stalling the data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                        tmo_cnt <= TMO_LOAD;
    else if (state != S_DATA || hready)  tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != '0)              tmo_cnt <= tmo_cnt - 1'b1;
  end

  assign tmo_hit = (state == S_DATA) && !hready && (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

endmodule
